adder_seq_arbiter: RTL and testbench

Shares one `carry_skip_adder` instance among `NREQ` requesters and runs wide additions of `N*WORDS` bits word-serially through it, one `N`-bit slice per cycle, chaining the carry between slices. Requesters are granted round-robin. The block sits between operand producers and the shared adder, and returns a tagged result on a valid/ready response channel.

---
 rtl/adder_seq_pkg.sv | 39 +++
 rtl/adder_seq_rr_arb.sv | 29 ++
 rtl/carry_skip_adder.sv | 38 +++
 rtl/adder_seq_arbiter.sv | 146 ++++++++++++++
 tb/tb_adder_seq_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the word-serial shared-adder arbiter.
// Combinational only; no latency or backpressure of its own.
package adder_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int MAX_REQ = 8;

  function automatic int calc_w(input int n, input int words);
    return n * words;
  endfunction

  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // First valid requester searching upward from last+1, wrapping at nreq.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] last,
                                 input int nreq);
    int pick;
    int idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = (int'(last) + i) % nreq;
      if (i <= nreq && !found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/adder_seq_rr_arb.sv
// Combinational round-robin grant: one-hot grant plus encoded index, searching
// upward from last+1. Zero latency; the caller decides when a grant is taken.
module adder_seq_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);
  import adder_seq_pkg::*;

  logic [MAX_REQ-1:0] valid_ext;
  logic [2:0]         last_ext;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NREQ-1:0]    = req_valid;
    last_ext               = '0;
    last_ext[IDW-1:0]      = last;
    gnt_any                = |req_valid;
    gnt_idx                = IDW'(rr_pick(valid_ext, last_ext, NREQ));
    gnt                    = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/carry_skip_adder.sv
// N-bit carry-skip adder: ripple inside each block, block carry bypassed when the
// whole block propagates. Purely combinational, no backpressure.
module carry_skip_adder #(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin : add
    logic [N:0] c;
    logic       blk_p;
    logic       blk_cin;
    c       = '0;
    sum     = '0;
    blk_p   = 1'b1;
    blk_cin = cin;
    c[0]    = cin;
    for (int i = 0; i < N; i++) begin
      if ((i % BLOCK_SIZE) == 0) begin
        blk_p   = 1'b1;
        blk_cin = c[i];
      end
      blk_p    = blk_p & (a[i] ^ b[i]);
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
      if (((i % BLOCK_SIZE) == (BLOCK_SIZE - 1)) || (i == N - 1)) begin
        c[i+1] = blk_p ? blk_cin : c[i+1];
      end
    end
    cout = c[N];
  end

endmodule

// File: rtl/adder_seq_arbiter.sv
// Round-robin shares one carry_skip_adder, adding N*WORDS-bit operands one slice per cycle.
// rsp_valid WORDS edges after accept; DONE holds until rsp_ready. ADDER_SEQ_OVF_EN adds rsp_ovf.
module adder_seq_arbiter #(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int WORDS      = 4,
  parameter int NREQ       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*N*WORDS-1:0]      req_a,
  input  logic [NREQ*N*WORDS-1:0]      req_b,
  input  logic [NREQ-1:0]              req_cin,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [N*WORDS-1:0]           rsp_sum,
  output logic                         rsp_cout,
`ifdef ADDER_SEQ_OVF_EN
  output logic                         rsp_ovf,
`endif
  output logic [$clog2(NREQ)-1:0]      rsp_id
);
  import adder_seq_pkg::*;

  localparam int W   = calc_w(N, WORDS);
  localparam int IDW = id_w(NREQ);
  localparam int KW  = cnt_w(WORDS);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDW-1:0]   id_q, id_d, last_q, last_d;
`ifdef ADDER_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [N-1:0]     a_sl, b_sl, s_sl;
  logic             c_sl;

  adder_seq_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_valid (req_valid),
    .last      (last_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  assign a_sl = a_q[k_q*N +: N];
  assign b_sl = b_q[k_q*N +: N];

  carry_skip_adder #(.N(N), .BLOCK_SIZE(BLOCK_SIZE)) u_add (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (s_sl),
    .cout (c_sl)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    id_d      = id_q;
    last_d    = last_q;
`ifdef ADDER_SEQ_OVF_EN
    ovf_d     = ovf_q;
`endif
    req_ready = '0;
    case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (gnt_any) begin
          a_d     = req_a[gnt_idx*W +: W];
          b_d     = req_b[gnt_idx*W +: W];
          carry_d = req_cin[gnt_idx];
          id_d    = gnt_idx;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[k_q*N +: N] = s_sl;
        carry_d           = c_sl;
        k_d               = k_q + KW'(1);
`ifdef ADDER_SEQ_OVF_EN
        // Carry into the top bit, recovered from the slice sum, versus carry out.
        ovf_d             = s_sl[N-1] ^ a_sl[N-1] ^ b_sl[N-1] ^ c_sl;
`endif
        if (k_q == KW'(WORDS - 1)) begin
          state_d = DONE;
          last_d  = id_q;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      last_q  <= last_d;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;
`ifdef ADDER_SEQ_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Scoreboard bench for adder_seq_arbiter: per-requester drivers push expected results,
// a monitor pops and compares on every response handshake.
module tb_adder_seq_arbiter;

  localparam int N = 8, BS = 4, WORDS = 4, NREQ = 2, W = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        chk;
  } cmd_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_cin;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_cout;
  logic [31:0] rsp_sum;
  logic [0:0]  rsp_id;
`ifdef ADDER_SEQ_OVF_EN
  logic        rsp_ovf;
`endif

  logic        v0, v1, c0, c1;
  logic [31:0] a0, a1, b0, b1;
  assign req_valid = {v1, v0};
  assign req_cin   = {c1, c0};
  assign req_a     = {a1, a0};
  assign req_b     = {b1, b0};

  cmd_t cmd0[$], cmd1[$];
  exp_t exp0[$], exp1[$];
  int   got_ids[$];
  int   n_cmp = 0, n_err = 0, n_rsp = 0;
  logic rnd_mode = 1'b0, rdy_fixed = 1'b1;

  always #5 clk = ~clk;

  adder_seq_arbiter #(.N(N), .BLOCK_SIZE(BS), .WORDS(WORDS), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
`ifdef ADDER_SEQ_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_id    (rsp_id)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input logic chk_en);
    cmd_t c;
    c.a = a; c.b = b; c.cin = cin; c.chk = chk_en;
    return c;
  endfunction

  function automatic exp_t model(input cmd_t c);
    logic [32:0] full;
    exp_t e;
    full   = {1'b0, c.a} + {1'b0, c.b} + {32'b0, c.cin};
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (c.a[31] ^ c.b[31] ^ full[31]) ^ full[32];
    return e;
  endfunction

  initial begin : drv0
    cmd_t c;
    logic ok;
    v0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && cmd0.size() > 0) begin
        c = cmd0.pop_front();
        if (c.chk) exp0.push_back(model(c));
        v0 = 1'b1; a0 = c.a; b0 = c.b; c0 = c.cin; ok = 1'b0;
        for (int t = 0; t < 5000 && !ok; t++) begin
          @(negedge clk);
          if (req_ready[0]) begin
            ok = 1'b1;
            @(posedge clk); #1;
          end
        end
        v0 = 1'b0;
        chk("drv0_grant", 64'(ok), 64'd1);
      end
    end
  end

  initial begin : drv1
    cmd_t c;
    logic ok;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && cmd1.size() > 0) begin
        c = cmd1.pop_front();
        if (c.chk) exp1.push_back(model(c));
        v1 = 1'b1; a1 = c.a; b1 = c.b; c1 = c.cin; ok = 1'b0;
        for (int t = 0; t < 5000 && !ok; t++) begin
          @(negedge clk);
          if (req_ready[1]) begin
            ok = 1'b1;
            @(posedge clk); #1;
          end
        end
        v1 = 1'b0;
        chk("drv1_grant", 64'(ok), 64'd1);
      end
    end
  end

  initial begin : rsp_drv
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end
  end

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        n_rsp++;
        got_ids.push_back(int'(rsp_id));
        if ((rsp_id == 1'b0 && exp0.size() == 0) || (rsp_id == 1'b1 && exp1.size() == 0)) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: id %0d sum 0x%0h with nothing outstanding, required no response",
                   rsp_id, rsp_sum);
        end else begin
          if (rsp_id == 1'b0) e = exp0.pop_front();
          else                e = exp1.pop_front();
          chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
          chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
`ifdef ADDER_SEQ_OVF_EN
          chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
`endif
        end
      end
    end
  end

  task automatic drain(input int limit);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < limit && !ok; t++) begin
      @(negedge clk);
      if (cmd0.size() == 0 && cmd1.size() == 0 && exp0.size() == 0 && exp1.size() == 0 &&
          !v0 && !v1 && !rsp_valid) ok = 1'b1;
    end
    chk("drain", 64'(ok), 64'd1);
  endtask

  task automatic wait_ready(input int r);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1'b1;
    end
    chk("wait_ready", 64'(ok), 64'd1);
  endtask

  initial begin : main
    int   lat;
    logic seen;
    int   base;
    int   exp_ord[4];
    exp_ord = '{0, 1, 0, 1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_sum",   64'(rsp_sum),   64'd0);
    chk("rst_cout",  64'(rsp_cout),  64'd0);
    chk("rst_id",    64'(rsp_id),    64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);

    // Single op with latency measurement from the accept edge.
    cmd0.push_back(mk(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1));
    wait_ready(0);
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!rsp_valid && lat < 20);
    chk("latency", 64'(lat), 64'd4);
    chk("single_id", 64'(rsp_id), 64'd0);
    drain(100);

    // Full carry chain held under backpressure, then a signed-overflow op from r1.
    rdy_fixed = 1'b0;
    cmd0.push_back(mk(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1));
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("bp_reach_done", 64'(seen), 64'd1);
    cmd1.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_sum",   64'(rsp_sum),   64'd0);
      chk("bp_cout",  64'(rsp_cout),  64'd1);
      chk("bp_ready", 64'(req_ready), 64'd0);
    end
    rdy_fixed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hs_then_idle_valid", 64'(rsp_valid), 64'd0);
    chk("hs_then_idle_grant", 64'(req_ready), 64'b10);
    drain(100);

    // Reset mid-RUN: make r0 the last winner, then abort an r1 op at k=2.
    cmd0.push_back(mk(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b1));
    drain(100);
    cmd1.push_back(mk(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0));
    wait_ready(1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_sum",   64'(rsp_sum),   64'd0);
    chk("mid_rst_cout",  64'(rsp_cout),  64'd0);
    chk("mid_rst_id",    64'(rsp_id),    64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 64'(seen), 64'd0);

    // Contention: both requesters continuously valid; reset left last=1 so r0 goes first.
    got_ids.delete();
    cmd0.push_back(mk(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1));
    cmd1.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1));
    cmd0.push_back(mk(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b1));
    cmd1.push_back(mk(32'h00FF_00FF, 32'hFF00_FF00, 1'b1, 1'b1));
    drain(200);
    chk("grant_count", 64'(got_ids.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_ids.size()) chk("grant_order", 64'(got_ids[i]), 64'(exp_ord[i]));
    end

    // Random regression with random response stalls.
    rnd_mode = 1'b1;
    base = n_rsp;
    for (int i = 0; i < 500; i++) begin
      cmd0.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1));
      cmd1.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1));
    end
    drain(40000);
    chk("rnd_rsp_count", 64'(n_rsp - base), 64'd1000);
    chk("rnd_outstanding", 64'(exp0.size() + exp1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
